// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
package fetch_pkg;
  localparam int INSTR_WIDTH = 32;
  localparam int ADDR_WIDTH  = 32;

  typedef logic [INSTR_WIDTH-1:0] instr_t;
  typedef logic [ADDR_WIDTH-1:0]  addr_t;

  localparam instr_t NOP_INSTR        = 32'h0000_0000;
  localparam addr_t  DEFAULT_RESET_PC = 32'd0;

  // One fetched word together with the word address it came from.
  typedef struct packed {
    instr_t instr;
    addr_t  pc;
  } fetch_entry_t;

  // Word-indexed increment; wraps modulo 2^32 by construction.
  function automatic addr_t next_pc(input addr_t pc, input addr_t step);
    return pc + step;
  endfunction
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Memory-side and decode-side signals of the fetch unit, bundled for port use.
interface instruction_fetch_unit_if;
  import fetch_pkg::*;

  addr_t  imem_address;
  instr_t imem_instruction;
  logic   stall;
  logic   branch_taken;
  addr_t  branch_target;
  instr_t instruction;
  addr_t  instr_pc;
  logic   instr_valid;

  modport master (
    output imem_address,
    input  imem_instruction,
    input  stall,
    input  branch_taken,
    input  branch_target,
    output instruction,
    output instr_pc,
    output instr_valid
  );

  modport slave (
    input  imem_address,
    output imem_instruction,
    output stall,
    output branch_taken,
    output branch_target,
    input  instruction,
    input  instr_pc,
    input  instr_valid
  );
endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a memory response that arrives while decode stalls.
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         capture,
  input  logic         drain,
  input  logic         flush,
  input  fetch_entry_t in_entry,
  output logic         valid,
  output fetch_entry_t entry
);

  logic         valid_r;
  fetch_entry_t entry_r;

  // Flush wins over capture so a redirect never leaves a stale word behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
      entry_r <= '{instr: NOP_INSTR, pc: 32'd0};
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (capture) begin
      valid_r <= 1'b1;
      entry_r <= in_entry;
    end else if (drain) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign valid = valid_r;
  assign entry = entry_r;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Program counter, one-cycle memory latency absorption and registered decode outputs.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter addr_t RESET_PC = DEFAULT_RESET_PC,
  parameter addr_t PC_STEP  = 32'd1
) (
  input logic                      clk,
  input logic                      rst,
  instruction_fetch_unit_if.master bus
);

  addr_t        fetch_pc_r;
  logic         issued_r;
  addr_t        resp_pc_r;
  instr_t       instruction_r;
  addr_t        instr_pc_r;
  logic         instr_valid_r;

  logic         skid_capture_s;
  logic         skid_drain_s;
  logic         skid_flush_s;
  logic         skid_valid_s;
  fetch_entry_t skid_entry_s;
  fetch_entry_t resp_entry_s;

  // Skid control: capture the in-flight word only on the first stalled cycle.
  always_comb begin
    skid_flush_s   = bus.branch_taken;
    skid_capture_s = 1'b0;
    skid_drain_s   = 1'b0;
    if (!bus.branch_taken) begin
      skid_capture_s = bus.stall && issued_r && !skid_valid_s;
      skid_drain_s   = !bus.stall && skid_valid_s;
    end else begin
      skid_capture_s = 1'b0;
      skid_drain_s   = 1'b0;
    end
    resp_entry_s = '{instr: bus.imem_instruction, pc: resp_pc_r};
  end

  fetch_skid_buffer u_skid (
    .clk      (clk),
    .rst      (rst),
    .capture  (skid_capture_s),
    .drain    (skid_drain_s),
    .flush    (skid_flush_s),
    .in_entry (resp_entry_s),
    .valid    (skid_valid_s),
    .entry    (skid_entry_s)
  );

  // PC sequencing and output register; branch has priority over stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_r    <= RESET_PC;
      issued_r      <= 1'b0;
      resp_pc_r     <= 32'd0;
      instruction_r <= NOP_INSTR;
      instr_pc_r    <= 32'd0;
      instr_valid_r <= 1'b0;
    end else if (bus.branch_taken) begin
      fetch_pc_r    <= bus.branch_target;
      issued_r      <= 1'b0;
      instr_valid_r <= 1'b0;
    end else if (bus.stall) begin
      // Address stays on the bus but its response is dropped; it is refetched on release.
      issued_r      <= 1'b0;
    end else begin
      issued_r      <= 1'b1;
      resp_pc_r     <= fetch_pc_r;
      fetch_pc_r    <= next_pc(fetch_pc_r, PC_STEP);
      if (skid_valid_s) begin
        instruction_r <= skid_entry_s.instr;
        instr_pc_r    <= skid_entry_s.pc;
        instr_valid_r <= 1'b1;
      end else begin
        instruction_r <= bus.imem_instruction;
        instr_pc_r    <= resp_pc_r;
        instr_valid_r <= issued_r;
      end
    end
  end

  assign bus.imem_address = fetch_pc_r;
  assign bus.instruction  = instruction_r;
  assign bus.instr_pc     = instr_pc_r;
  assign bus.instr_valid  = instr_valid_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed, table-driven bench for instruction_fetch_unit with a word-indexed memory model.
module tb_instruction_fetch_unit;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  instruction_fetch_unit_if bus();

  instruction_fetch_unit #(.RESET_PC(32'd0), .PC_STEP(32'd1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: mem[i] = A000_0000 + i, one cycle read latency.
  always @(posedge clk) bus.imem_instruction <= 32'hA000_0000 + bus.imem_address;

  typedef struct {
    logic        stall;
    logic        branch;
    logic [31:0] target;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic s, input logic b, input logic [31:0] t,
                              input logic v, input logic [31:0] pc);
    vec_t e;
    e.stall = s; e.branch = b; e.target = t; e.exp_valid = v; e.exp_pc = pc;
    vecs.push_back(e);
  endfunction

  function automatic logic [31:0] exp_instr(input logic [31:0] pc);
    return 32'hA000_0000 + pc;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic v, input logic [31:0] pc);
    check({name, ".valid"}, {31'd0, bus.instr_valid}, {31'd0, v});
    if (v) begin
      check({name, ".pc"}, bus.instr_pc, pc);
      check({name, ".instr"}, bus.instruction, exp_instr(pc));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = 32'd0;

    // Straight line from reset, then stall 1 cycle at pc 4 and 3 cycles at pc 7.
    add(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    for (int i = 0; i <= 4; i++) add(1'b0, 1'b0, 32'd0, 1'b1, i);
    add(1'b1, 1'b0, 32'd0, 1'b1, 32'd4);
    for (int i = 5; i <= 7; i++) add(1'b0, 1'b0, 32'd0, 1'b1, i);
    for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 32'd0, 1'b1, 32'd7);
    for (int i = 8; i <= 10; i++) add(1'b0, 1'b0, 32'd0, 1'b1, i);
    // Branch to 20 from a free-running stream.
    add(1'b0, 1'b1, 32'd20, 1'b0, 32'd0);
    add(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    for (int i = 20; i <= 22; i++) add(1'b0, 1'b0, 32'd0, 1'b1, i);
    // Stall fills the skid with pc 23, then a branch discards it.
    add(1'b1, 1'b0, 32'd0, 1'b1, 32'd22);
    add(1'b1, 1'b0, 32'd0, 1'b1, 32'd22);
    add(1'b1, 1'b1, 32'd20, 1'b0, 32'd0);
    add(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    add(1'b0, 1'b0, 32'd0, 1'b1, 32'd20);
    add(1'b0, 1'b0, 32'd0, 1'b1, 32'd21);
    // Stall inside the flush shadow.
    add(1'b0, 1'b1, 32'd50, 1'b0, 32'd0);
    add(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    add(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    add(1'b0, 1'b0, 32'd0, 1'b1, 32'd50);
    add(1'b0, 1'b0, 32'd0, 1'b1, 32'd51);
    // Address wrap.
    add(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'd0);
    add(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    add(1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFF);
    add(1'b0, 1'b0, 32'd0, 1'b1, 32'd0);
    add(1'b0, 1'b0, 32'd0, 1'b1, 32'd1);

    tick();
    tick();
    check("reset.valid", {31'd0, bus.instr_valid}, 32'd0);
    check("reset.pc", bus.instr_pc, 32'd0);
    check("reset.instr", bus.instruction, 32'd0);
    check("reset.addr", bus.imem_address, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      bus.stall = vecs[i].stall;
      bus.branch_taken = vecs[i].branch;
      bus.branch_target = vecs[i].target;
      tick();
      check_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc);
    end
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;

    // Asynchronous reset pulse between clock edges.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("areset.valid", {31'd0, bus.instr_valid}, 32'd0);
    check("areset.pc", bus.instr_pc, 32'd0);
    check("areset.instr", bus.instruction, 32'd0);
    check("areset.addr", bus.imem_address, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check_out("restart0", 1'b0, 32'd0);
    for (int i = 0; i <= 3; i++) begin
      tick();
      check_out($sformatf("restart_pc%0d", i), 1'b1, i);
    end

    // Branch to 20 while pc 3 sits on the output.
    bus.branch_taken = 1'b1;
    bus.branch_target = 32'd20;
    tick();
    check_out("br.n1", 1'b0, 32'd0);
    bus.branch_taken = 1'b0;
    tick();
    check_out("br.n2", 1'b0, 32'd0);
    tick();
    check_out("br.n3", 1'b1, 32'd20);
    tick();
    check_out("br.n4", 1'b1, 32'd21);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Initiator side of the 32-bit synchronous instruction memory. Owns the program counter and drives the word address.
- Absorbs the memory's one-cycle registered read latency and delivers a registered instruction, PC and valid to decode.
- Supports decode back-pressure (stall) and branch redirect without losing or duplicating instructions.

Parameters:
- RESET_PC, 32'd0, word index fetched first after reset.
- PC_STEP, 32'd1, PC increment per issued fetch (memory is word-indexed).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_address  output  32  word address to instruction memory; equals fetch_pc.
- imem_instruction  input  32  memory data; the word at the address presented on the previous clk edge.
- stall  input  1  decode cannot accept; hold outputs.
- branch_taken  input  1  redirect request, sampled on the clk edge.
- branch_target  input  32  word index to fetch next when branch_taken=1.
- instruction  output  32  instruction to decode.
- instr_pc  output  32  word address of instruction.
- instr_valid  output  1  instruction/instr_pc are meaningful.

Behaviour:
- Reset (async, immediate):
  - fetch_pc=RESET_PC; issued=0; resp_pc=0.
  - skid_valid=0; skid_instr=0; skid_pc=0.
  - instruction=0; instr_pc=0; instr_valid=0.
- Internal state:
  - fetch_pc: drives imem_address combinationally.
  - issued/resp_pc: imem_instruction is valid this cycle for word resp_pc.
  - One-entry skid register.
- Normal cycle (no stall, no branch):
  - issued<=1; resp_pc<=fetch_pc; fetch_pc<=fetch_pc+PC_STEP (mod 2^32, 0xFFFFFFFF wraps to 0).
  - Output register takes the response: instruction<=imem_instruction, instr_pc<=resp_pc, instr_valid<=issued.
- Latency: address presented in cycle n -> word on imem_instruction in n+1 -> on outputs in n+2.
  - First valid output after reset release: cycle 2, instr_pc=RESET_PC.
  - Then one instruction per cycle.
- Stall=1, branch_taken=0:
  - Outputs hold.
  - fetch_pc holds; issued<=0.
  - If issued=1 and skid_valid=0: skid captures imem_instruction/resp_pc and skid_valid<=1.
- Stall release (stall=0, skid_valid=1):
  - Outputs take the skid contents with instr_valid=1; skid_valid<=0.
  - Fetch issue resumes in the same cycle. No bubble, no duplicate.
- Branch (branch_taken=1, any stall value; branch has priority):
  - fetch_pc<=branch_target; issued<=0; skid_valid<=0; instr_valid<=0.
  - The in-flight response is discarded.
  - Target word appears on outputs 3 cycles after the branch edge (cycle n+3), instr_pc=branch_target.
- Stall asserted during the flush shadow: no skid capture while issued=0; fetch_pc holds the target.
- instr_valid=0 outputs: instruction/instr_pc may carry stale values; decode treats them as NOP.
- Reset asserted mid-stall or mid-branch: all state cleared immediately; restart from RESET_PC.
- No combinational path from stall or branch_taken to any output.

Decomposition:
- Shared package (fetch_pkg): INSTR_WIDTH=32, ADDR_WIDTH=32, NOP_INSTR=32'h0000_0000, DEFAULT_RESET_PC=32'd0.
- One natural sub-module: fetch_skid_buffer. It holds the 1-entry instruction+pc register with capture/drain/flush controls.
- PC and output-register logic stay in the top module.

Test Plan:
- Reset + straight-line: memory model mem[i]=32'hA000_0000+i, no stall.
  - Required: instr_valid first high at cycle 2 after reset release.
  - Sequence 0xA0000000, 0xA0000001, ... with instr_pc 0,1,2..., one per cycle.
- Single-cycle stall while output holds pc=4:
  - Outputs hold pc=4 during the stall.
  - Next cycle pc=5, then 6. No gaps, no repeats.
- 3-cycle stall at pc=7:
  - Skid holds pc=8.
  - After release the sequence is 7(held), 8, 9, 10 consecutively.
- Branch at cycle n with target=20 while pc=3 is on the output:
  - instr_valid=0 at n+1 and n+2.
  - n+3: instr_pc=20, instruction=0xA0000014, then 21.
- Branch with stall=1 and skid full:
  - Skid discarded; pc=20 appears at n+3 once stall drops.
  - The previously skidded word never appears.
- Async reset pulse mid-stream:
  - Outputs go to 0/invalid immediately, with no clk edge.
  - After release, fetching restarts at RESET_PC.
  - Wrap check: branch to 0xFFFFFFFF gives instr_pc 0xFFFFFFFF then 0x00000000.
